sysctl_timer_wb: RTL



---
 rtl/sysctl_timer_wb_if.sv | 25 ++
 rtl/sysctl_timer_wb.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sysctl_timer_wb_if.sv
// Wishbone slave-side bus bundle for sysctl_timer_wb.
// Signal names follow the Wishbone convention; the modports give the interconnect and responder views.
interface sysctl_timer_wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            wbs_stb_i;
  logic            wbs_cyc_i;
  logic            wbs_we_i;
  logic [DW/8-1:0] wbs_sel_i;
  logic [AW-1:0]   wbs_adr_i;
  logic [DW-1:0]   wbs_dat_i;
  logic [DW-1:0]   wbs_dat_o;
  logic            wbs_ack_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/sysctl_timer_wb.sv
// System Control timer: Wishbone slave with a prescaled 32-bit down-counter, sticky expiry flag and level IRQ.
// Define SYSCTL_TIMER_IRQ_EN to implement the IRQ_EN control bit and drive irq_o; otherwise irq_o is tied low.
module sysctl_timer_wb #(
  parameter int PSW = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  sysctl_timer_wb_if.slave   wb,
  output logic               irq_o
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_RELOAD   = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  logic           en;
  logic           periodic;
  logic           irq_en;
  logic           expired;
  logic [PSW-1:0] prescale;
  logic [PSW-1:0] pcnt;
  logic [31:0]    reload;
  logic [31:0]    count;
  logic [31:0]    rd_data;
  logic [31:0]    wmask;

  logic       req;
  logic       accept;
  logic       wr;
  logic [2:0] off;
  logic       wr_ctrl;
  logic       wr_prescale;
  logic       wr_reload;
  logic       wr_count;
  logic       clr_status;
  logic       en_write;
  logic       tick;
  logic       expire;
  logic       unused_adr;

  assign off    = wb.wbs_adr_i[4:2];
  assign req    = wb.wbs_stb_i & wb.wbs_cyc_i;
  // A new transfer is taken only when ack is low, giving one ack per two cycles under a held strobe.
  assign accept = req & ~wb.wbs_ack_o;
  assign wr     = accept & wb.wbs_we_i;

  assign wr_ctrl     = wr && (off == REG_CTRL);
  assign wr_prescale = wr && (off == REG_PRESCALE);
  assign wr_reload   = wr && (off == REG_RELOAD);
  assign wr_count    = wr && (off == REG_COUNT);
  assign clr_status  = wr && (off == REG_STATUS) && wb.wbs_sel_i[0] && wb.wbs_dat_i[0];
  assign en_write    = wr_ctrl && wb.wbs_sel_i[0];

  assign tick   = en && (pcnt == prescale);
  assign expire = tick && (count == '0);

  assign wmask = {{8{wb.wbs_sel_i[3]}}, {8{wb.wbs_sel_i[2]}},
                  {8{wb.wbs_sel_i[1]}}, {8{wb.wbs_sel_i[0]}}};

  // Only adr[4:2] is decoded; the rest belongs to the interconnect.
  assign unused_adr = ^{wb.wbs_adr_i[$bits(wb.wbs_adr_i)-1:5], wb.wbs_adr_i[1:0]};

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rd_data = '0;
    case (off)
      REG_CTRL:     rd_data[2:0]     = {irq_en, periodic, en};
      REG_PRESCALE: rd_data[PSW-1:0] = prescale;
      REG_RELOAD:   rd_data          = reload;
      REG_COUNT:    rd_data          = count;
      REG_STATUS:   rd_data[0]       = expired;
      default:      rd_data          = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments; reset is synchronous and has priority.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      en           <= 1'b0;
      periodic     <= 1'b0;
      expired      <= 1'b0;
      prescale     <= '0;
      pcnt         <= '0;
      reload       <= '0;
      count        <= '0;
    end else begin
      wb.wbs_ack_o <= accept;
      wb.wbs_dat_o <= accept ? rd_data : '0;

      if (en_write && wb.wbs_dat_i[0]) begin
        pcnt <= '0;
      end else if (tick) begin
        pcnt <= '0;
      end else if (en) begin
        pcnt <= pcnt + PSW'(1);
      end

      // A bus write of CTRL overrides the one-shot auto-disable.
      if (en_write) begin
        en       <= wb.wbs_dat_i[0];
        periodic <= wb.wbs_dat_i[1];
      end else if (expire && !periodic) begin
        en <= 1'b0;
      end

      if (wr_prescale) begin
        prescale <= (prescale & ~wmask[PSW-1:0]) | (wb.wbs_dat_i[PSW-1:0] & wmask[PSW-1:0]);
      end

      if (wr_reload) begin
        reload <= (reload & ~wmask) | (wb.wbs_dat_i & wmask);
      end

      if (wr_count) begin
        count <= (count & ~wmask) | (wb.wbs_dat_i & wmask);
      end else if (tick) begin
        if (count != '0) begin
          count <= count - 32'd1;
        end else if (periodic) begin
          count <= reload;
        end
      end

      // Expiry takes precedence over a simultaneous write-1-to-clear.
      if (expire) begin
        expired <= 1'b1;
      end else if (clr_status) begin
        expired <= 1'b0;
      end
    end
  end

`ifdef SYSCTL_TIMER_IRQ_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en <= 1'b0;
    end else if (en_write) begin
      irq_en <= wb.wbs_dat_i[2];
    end
  end

  assign irq_o = expired & irq_en;
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

endmodule
